pc_src_controller: RTL and testbench

- Sequencer that drives the PC-source select and PC/EPC write enables of the multicycle CPU datapath.
- Takes one PC-update request at a time from the main control unit: sequential, branch, jump, jr, rte or exception.
- Runs the multi-cycle exception entry: save EPC, read the handler vector byte from memory, load PC from the sign-extended memory data.
- Guarantees the PC-source select never leaves the five legal encodings.

---
 rtl/pc_ctrl_pkg.sv | 32 +++
 rtl/pc_vec_wait_counter.sv | 20 ++
 rtl/pc_src_controller.sv | 90 +++++++++
 tb/tb_pc_src_controller.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: PC-source encodings, op/cause codes and FSM states for pc_src_controller.
package pc_ctrl_pkg;
  localparam logic [2:0] PCSRC_ALU_DIRECT = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT     = 3'b001;
  localparam logic [2:0] PCSRC_JUMP       = 3'b010;
  localparam logic [2:0] PCSRC_MEMSEXT    = 3'b011;
  localparam logic [2:0] PCSRC_EPC        = 3'b100;
  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JR     = 3'b011;
  localparam logic [2:0] OP_RTE    = 3'b100;
  localparam logic [2:0] OP_EXC    = 3'b101;
  localparam logic [1:0] CAUSE_INVALID_OP = 2'b00;
  localparam logic [1:0] CAUSE_OVERFLOW   = 2'b01;
  localparam logic [1:0] CAUSE_DIV_ZERO   = 2'b10;
  localparam logic [1:0] CAUSE_RSVD       = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UPDATE   = 3'd1,
    ST_EPC_SAVE = 3'd2,
    ST_VEC_READ = 3'd3,
    ST_LOAD_PC  = 3'd4,
    ST_HALT     = 3'd5
  } state_t;
  // An untaken branch writes nothing, so its select stays at the safe default.
  function automatic logic [2:0] pcsrc_for(input logic [2:0] op, input logic taken);
    return (op == OP_BRANCH) ? (taken ? PCSRC_ALUOUT : PCSRC_ALU_DIRECT) :
           (op == OP_JUMP)   ? PCSRC_JUMP :
           (op == OP_RTE)    ? PCSRC_EPC  : PCSRC_ALU_DIRECT;
  endfunction
endpackage

// File: rtl/pc_vec_wait_counter.sv
// pc_vec_wait_counter: MEM_LATENCY down-counter; load on entry, expire on the last wait cycle.
module pc_vec_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY);
  localparam logic [W-1:0] LOAD_VAL = W'(MEM_LATENCY - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= LOAD_VAL;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_expire = (r_cnt == '0);
endmodule

// File: rtl/pc_src_controller.sv
// pc_src_controller: PC-source/PC/EPC write sequencer with multi-cycle exception entry.
// Define PC_SRC_DBLFAULT_EN to halt on an exception taken while already in a handler.
module pc_src_controller
  import pc_ctrl_pkg::*;
#(
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] VEC_BASE    = 32'd253
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic        branch_taken,
  input  logic [1:0]  exc_cause,
  output logic        ready,
  output logic [2:0]  pc_src_sel,
  output logic        pc_write,
  output logic        epc_write,
  output logic        mem_read,
  output logic [31:0] exc_addr,
  output logic        done,
  output logic        in_handler,
  output logic        halted
);
  state_t     r_state, w_next;
  logic [2:0] r_op;
  logic       r_taken;
  logic [1:0] r_cause;
  logic       r_in_handler;
  logic       w_accept, w_expire, w_upd_write;
  logic [1:0] w_cause_idx;
  state_t     w_exc_target;
  pc_vec_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state == ST_EPC_SAVE),
    .i_en     (r_state == ST_VEC_READ),
    .o_expire (w_expire)
  );
  assign w_accept = req && (r_state == ST_IDLE);
`ifdef PC_SRC_DBLFAULT_EN
  assign w_exc_target = r_in_handler ? ST_HALT : ST_EPC_SAVE;
  assign halted       = (r_state == ST_HALT);
`else
  assign w_exc_target = ST_EPC_SAVE;
  assign halted       = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     w_next = !w_accept || op > OP_EXC ? ST_IDLE :
                            (op == OP_EXC) ? w_exc_target : ST_UPDATE;
      ST_UPDATE:   w_next = ST_IDLE;
      ST_EPC_SAVE: w_next = ST_VEC_READ;
      ST_VEC_READ: w_next = w_expire ? ST_LOAD_PC : ST_VEC_READ;
      ST_LOAD_PC:  w_next = ST_IDLE;
      ST_HALT:     w_next = ST_HALT;
      default:     w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_SEQ;
      r_taken      <= 1'b0;
      r_cause      <= CAUSE_INVALID_OP;
      r_in_handler <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= op;
        r_taken <= branch_taken;
        r_cause <= exc_cause;
      end
      if (r_state == ST_LOAD_PC) r_in_handler <= 1'b1;
      else if (r_state == ST_UPDATE && r_op == OP_RTE) r_in_handler <= 1'b0;
    end
  end
  assign w_upd_write = !(r_op == OP_BRANCH && !r_taken);
  assign w_cause_idx = (r_cause == CAUSE_RSVD) ? CAUSE_INVALID_OP : r_cause;
  assign ready       = (r_state == ST_IDLE);
  assign pc_src_sel  = (r_state == ST_UPDATE)  ? pcsrc_for(r_op, r_taken) :
                       (r_state == ST_LOAD_PC) ? PCSRC_MEMSEXT : PCSRC_ALU_DIRECT;
  assign pc_write    = (r_state == ST_LOAD_PC) || (r_state == ST_UPDATE && w_upd_write);
  assign epc_write   = (r_state == ST_EPC_SAVE);
  assign mem_read    = (r_state == ST_VEC_READ);
  assign exc_addr    = mem_read ? VEC_BASE + 32'(w_cause_idx) : 32'd0;
  assign done        = (r_state == ST_UPDATE) || (r_state == ST_LOAD_PC);
  assign in_handler  = r_in_handler;
endmodule

// File: tb/tb_pc_src_controller.sv
// tb_pc_src_controller: directed checks of pc_src_controller with MEM_LATENCY=2, VEC_BASE=253.
module tb_pc_src_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        branch_taken = 1'b0;
  logic [1:0]  exc_cause = 2'd0;
  logic        ready, pc_write, epc_write, mem_read, done, in_handler, halted;
  logic [2:0]  pc_src_sel;
  logic [31:0] exc_addr;
  int checks = 0;
  int errors = 0;
  logic exp_ih;
  pc_src_controller #(.MEM_LATENCY(2), .VEC_BASE(32'd253)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .op           (op),
    .branch_taken (branch_taken),
    .exc_cause    (exc_cause),
    .ready        (ready),
    .pc_src_sel   (pc_src_sel),
    .pc_write     (pc_write),
    .epc_write    (epc_write),
    .mem_read     (mem_read),
    .exc_addr     (exc_addr),
    .done         (done),
    .in_handler   (in_handler),
    .halted       (halted)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Expected vector: {ready, sel[2:0], pc_write, epc_write, mem_read, done, in_handler, halted}
  function automatic logic [9:0] mk(input logic rdy, input logic [2:0] sel, input logic pw,
                                    input logic ew, input logic mr, input logic dn,
                                    input logic ih, input logic h);
    return {rdy, sel, pw, ew, mr, dn, ih, h};
  endfunction
  task automatic chk(input string tag, input logic [9:0] exp_v, input logic [31:0] exp_a);
    logic [9:0] obs;
    obs = {ready, pc_src_sel, pc_write, epc_write, mem_read, done, in_handler, halted};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp_v);
    end
    checks++;
    assert (exc_addr === exp_a) else begin
      errors++;
      $error("FAIL %s exc_addr observed=%0d expected=%0d", tag, exc_addr, exp_a);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic t, input logic [1:0] c);
    req = 1'b1; op = o; branch_taken = t; exc_cause = c;
    tick();
    req = 1'b0;
  endtask
  initial begin
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("reset_idle", mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 32'd0);
      tick();
    end
    issue(3'b010, 1'b0, 2'd0);
    chk("jump_update", mk(0, 3'b010, 1, 0, 0, 1, 0, 0), 32'd0);
    tick();
    chk("jump_ready", mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 32'd0);
    issue(3'b001, 1'b1, 2'd0);
    chk("branch_taken", mk(0, 3'b001, 1, 0, 0, 1, 0, 0), 32'd0);
    tick();
    issue(3'b001, 1'b0, 2'd0);
    chk("branch_not_taken", mk(0, 3'b000, 0, 0, 0, 1, 0, 0), 32'd0);
    tick();
    issue(3'b000, 1'b0, 2'd0);
    chk("seq_update", mk(0, 3'b000, 1, 0, 0, 1, 0, 0), 32'd0);
    tick();
    issue(3'b011, 1'b0, 2'd0);
    chk("jr_update", mk(0, 3'b000, 1, 0, 0, 1, 0, 0), 32'd0);
    tick();
    issue(3'b110, 1'b0, 2'd0);
    chk("reserved_ignored", mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 32'd0);
    tick();
    chk("reserved_no_done", mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 32'd0);
    issue(3'b101, 1'b0, 2'b01);
    chk("exc_epc_save", mk(0, 3'b000, 0, 1, 0, 0, 0, 0), 32'd0);
    req = 1'b1; op = 3'b000;
    tick();
    chk("exc_vec_read1", mk(0, 3'b000, 0, 0, 1, 0, 0, 0), 32'd254);
    tick();
    chk("exc_vec_read2", mk(0, 3'b000, 0, 0, 1, 0, 0, 0), 32'd254);
    tick();
    chk("exc_load_pc", mk(0, 3'b011, 1, 0, 0, 1, 0, 0), 32'd0);
    tick();
    chk("exc_idle_handler", mk(1, 3'b000, 0, 0, 0, 0, 1, 0), 32'd0);
    tick();
    req = 1'b0;
    chk("held_seq_accepted", mk(0, 3'b000, 1, 0, 0, 1, 1, 0), 32'd0);
    tick();
    chk("held_seq_done", mk(1, 3'b000, 0, 0, 0, 0, 1, 0), 32'd0);
    issue(3'b100, 1'b0, 2'd0);
    chk("rte_update", mk(0, 3'b100, 1, 0, 0, 1, 1, 0), 32'd0);
    tick();
    chk("rte_clears_handler", mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 32'd0);
    issue(3'b101, 1'b0, 2'b11);
    chk("exc3_epc_save", mk(0, 3'b000, 0, 1, 0, 0, 0, 0), 32'd0);
    tick();
    chk("exc3_vec_addr", mk(0, 3'b000, 0, 0, 1, 0, 0, 0), 32'd253);
    tick(); tick();
    chk("exc3_load_pc", mk(0, 3'b011, 1, 0, 0, 1, 0, 0), 32'd0);
    tick();
    chk("exc3_in_handler", mk(1, 3'b000, 0, 0, 0, 0, 1, 0), 32'd0);
`ifdef PC_SRC_DBLFAULT_EN
    issue(3'b101, 1'b0, 2'b10);
    chk("dblfault_halt", mk(0, 3'b000, 0, 0, 0, 0, 1, 1), 32'd0);
    req = 1'b1; op = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_sticky", mk(0, 3'b000, 0, 0, 0, 0, 1, 1), 32'd0);
    end
    req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_reset", mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 32'd0);
    exp_ih = 1'b0;
`else
    issue(3'b101, 1'b0, 2'b10);
    chk("nested_epc_save", mk(0, 3'b000, 0, 1, 0, 0, 1, 0), 32'd0);
    tick();
    chk("nested_vec1", mk(0, 3'b000, 0, 0, 1, 0, 1, 0), 32'd255);
    tick();
    chk("nested_vec2", mk(0, 3'b000, 0, 0, 1, 0, 1, 0), 32'd255);
    tick();
    chk("nested_load_pc", mk(0, 3'b011, 1, 0, 0, 1, 1, 0), 32'd0);
    tick();
    chk("nested_idle", mk(1, 3'b000, 0, 0, 0, 0, 1, 0), 32'd0);
    exp_ih = 1'b1;
`endif
    issue(3'b101, 1'b0, 2'b00);
    chk("mid_exc_epc", mk(0, 3'b000, 0, 1, 0, 0, exp_ih, 0), 32'd0);
    tick();
    chk("mid_exc_vec", mk(0, 3'b000, 0, 0, 1, 0, exp_ih, 0), 32'd253);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_exc", mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 32'd0);
    tick();
    chk("post_reset_idle", mk(1, 3'b000, 0, 0, 0, 0, 0, 0), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
